// File: rtl/elbeth_operand_issue_pkg.sv
// Types and constants shared by the operand-issue stage and the elbeth ALU.
package elbeth_operand_issue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd5;

endpackage

// File: rtl/elbeth_regfile.sv
// General register file: r0 reads zero, two combinational read ports with
// write-through bypass, one synchronous write port.
module elbeth_regfile
  import elbeth_operand_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // A write landing this edge is visible to the reader in the same cycle.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == '0)                            rs1_data_o = '0;
    else if (wb_en_i && (wb_addr_i == rs1_addr_i))   rs1_data_o = wb_data_i;

    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == '0)                            rs2_data_o = '0;
    else if (wb_en_i && (wb_addr_i == rs2_addr_i))   rs2_data_o = wb_data_i;
  end

endmodule

// File: rtl/elbeth_operand_issue.sv
// Operand-fetch/issue stage feeding elbeth_alu: reads operands at accept and
// holds them in a single valid/ready output register.
module elbeth_operand_issue
  import elbeth_operand_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [3:0]        in_operation,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [3:0]        operation,
  output logic [ADDR_W-1:0] out_rd
);

  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic              accept;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;

  elbeth_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (in_rs1),
    .rs2_addr_i (in_rs2),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .wb_en_i    (wb_en),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data)
  );

  // Held low while reset is asserted so nothing is taken during reset.
  assign in_ready = rst_n && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      data_a_d = rs1_val;
      data_b_d = in_use_imm ? in_imm : rs2_val;
      op_d     = in_operation;
      rd_d     = in_rd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign operation = op_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_elbeth_operand_issue.sv
// Directed self-checking bench for elbeth_operand_issue.
module tb_elbeth_operand_issue;
  import elbeth_operand_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  in_operation;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_a, data_b;
  logic [3:0]  operation;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  elbeth_operand_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_operation (in_operation),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_a       (data_a),
    .data_b       (data_b),
    .operation    (operation),
    .out_rd       (out_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] op, input logic use_imm, input logic [31:0] imm);
    in_valid     = 1'b1;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_operation = op;
    in_use_imm   = use_imm;
    in_imm       = imm;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    wb_en    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] rd);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".a"}, data_a, a);
    check({tag, ".b"}, data_b, b);
    check({tag, ".op"}, {28'd0, operation}, {28'd0, op});
    check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
  endtask

  logic [31:0] tp_a [4];

  initial begin
    rst_n = 1'b0;
    idle();
    out_ready = 1'b1;
    issue(5'd7, 5'd9, 5'd1, ALU_ADD, 1'b0, 32'h0);
    tick();
    tick();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.a", data_a, 32'd0);
    check("rst.b", data_b, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);

    rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_out("post_rst", 32'd0, 32'd0, ALU_ADD, 5'd1);

    idle();
    wb(5'd1, 32'd3);
    tick();
    check("drain.valid", {31'd0, out_valid}, 32'd0);
    wb(5'd2, 32'd4);
    tick();
    idle();
    issue(5'd1, 5'd2, 5'd5, ALU_ADD, 1'b0, 32'h0);
    tick();
    check_out("add", 32'd3, 32'd4, ALU_ADD, 5'd5);

    issue(5'd3, 5'd0, 5'd6, ALU_OR, 1'b1, 32'd5);
    wb(5'd3, 32'd10);
    tick();
    check_out("bypass", 32'd10, 32'd5, ALU_OR, 5'd6);

    idle();
    wb(5'd0, 32'd99);
    tick();
    idle();
    issue(5'd0, 5'd3, 5'd7, ALU_ADD, 1'b0, 32'h0);
    tick();
    check_out("r0", 32'd0, 32'd10, ALU_ADD, 5'd7);

    idle();
    wb(5'd4, 32'd5);
    tick();
    idle();
    issue(5'd4, 5'd0, 5'd8, ALU_SUB, 1'b1, 32'd2);
    out_ready = 1'b0;
    tick();
    check_out("stall.issue", 32'd5, 32'd2, ALU_SUB, 5'd8);
    issue(5'd4, 5'd1, 5'd6, ALU_ADD, 1'b0, 32'h0);
    wb(5'd4, 32'd77);
    for (int i = 0; i < 3; i++) begin
      check("stall.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check_out("stall.hold", 32'd5, 32'd2, ALU_SUB, 5'd8);
    end
    wb_en = 1'b0;
    out_ready = 1'b1;
    #1;
    check("stall.release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_out("stall.next", 32'd77, 32'd3, ALU_ADD, 5'd6);

    idle();
    wb(5'd5, 32'd3);
    tick();
    wb(5'd6, 32'd4);
    tick();
    idle();
    issue(5'd5, 5'd6, 5'd9, ALU_SLT, 1'b0, 32'h0);
    tick();
    check_out("slt", 32'd3, 32'd4, ALU_SLT, 5'd9);
    issue(5'd1, 5'd2, 5'd10, ALU_ADD, 1'b0, 32'h0);
    flush = 1'b1;
    wb(5'd7, 32'h1234);
    tick();
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    idle();
    tick();
    check("flush.valid2", {31'd0, out_valid}, 32'd0);
    issue(5'd7, 5'd0, 5'd11, ALU_ADD, 1'b0, 32'h0);
    tick();
    check_out("flush.wb_kept", 32'h1234, 32'd0, ALU_ADD, 5'd11);

    tp_a[0] = 32'd3;
    tp_a[1] = 32'd4;
    tp_a[2] = 32'd10;
    tp_a[3] = 32'd77;
    idle();
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 5'd0, 5'(i + 20), ALU_OR, 1'b1, 32'(i * 16));
      tick();
      check_out($sformatf("tput%0d", i), tp_a[i], 32'(i * 16), ALU_OR, 5'(i + 20));
    end
    idle();
    tick();
    check("tput.drain", {31'd0, out_valid}, 32'd0);

    issue(5'd4, 5'd1, 5'd12, ALU_SUB, 1'b0, 32'h0);
    out_ready = 1'b0;
    tick();
    check_out("midrst.issue", 32'd77, 32'd3, ALU_SUB, 5'd12);
    idle();
    rst_n = 1'b0;
    tick();
    check("midrst.valid", {31'd0, out_valid}, 32'd0);
    check("midrst.a", data_a, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(5'd4, 5'd1, 5'd13, ALU_ADD, 1'b0, 32'h0);
    tick();
    check_out("midrst.cleared", 32'd0, 32'd0, ALU_ADD, 5'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
